// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forward-mux selects,
// result-source code that marks a load, and the load-use FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } lu_state_e;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard unit signal bundle. The datapath is the master (drives
// stage register fields), the hazard unit is the slave (drives fwd/stall/flush).
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);

  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic              McOpD;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [1:0]        ResultSrcE;
  logic              McStartE;
  logic              PCSrcE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;
  logic              McDoneW;
  logic [REG_AW-1:0] McRdW;

  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              McBusy;

  modport master (
    output Rs1D, Rs2D, McOpD, Rs1E, Rs2E, RdE, ResultSrcE, McStartE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, McDoneW, McRdW,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, McBusy
  );

  modport slave (
    input  Rs1D, Rs2D, McOpD, Rs1E, Rs2E, RdE, ResultSrcE, McStartE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, McDoneW, McRdW,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, McBusy
  );

endinterface

// File: rtl/hazard_unit_mc_scoreboard.sv
// Pending-destination bits and outstanding-op counter for the out-of-order
// MUL/DIV unit, with two Decode-stage source queries.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int MC_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_vld,
  input  logic [REG_AW-1:0] i_set_rd,
  input  logic              i_clr_vld,
  input  logic [REG_AW-1:0] i_clr_rd,
  input  logic [REG_AW-1:0] i_q1_rd,
  input  logic [REG_AW-1:0] i_q2_rd,
  output logic              o_raw_hit,
  output logic              o_full,
  output logic              o_release,
  output logic              o_busy
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = $clog2(MC_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(MC_DEPTH);

  logic [NREG-1:0] r_pending;
  logic [CW-1:0]   r_cnt;

  logic w_set;
  logic w_clr;
  logic w_q1_hit;
  logic w_q2_hit;

  assign w_set = i_set_vld && (i_set_rd != '0);
  // A completion with nothing outstanding is a stale writeback (e.g. after reset).
  assign w_clr = i_clr_vld && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_clr) r_pending[i_clr_rd] <= 1'b0;
      if (w_set) r_pending[i_set_rd] <= 1'b1;
      if (w_set && !w_clr && (r_cnt != DEPTH_C)) r_cnt <= r_cnt + CW'(1);
      else if (w_clr && !w_set) r_cnt <= r_cnt - CW'(1);
    end
  end

  // The completing register is released in the same cycle it writes back.
  assign w_q1_hit = (i_q1_rd != '0) && r_pending[i_q1_rd] && !(w_clr && (i_clr_rd == i_q1_rd));
  assign w_q2_hit = (i_q2_rd != '0) && r_pending[i_q2_rd] && !(w_clr && (i_clr_rd == i_q2_rd));

  assign o_raw_hit = w_q1_hit || w_q2_hit;
  assign o_full    = (r_cnt == DEPTH_C);
  assign o_release = w_clr;
  assign o_busy    = (r_cnt != '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_clr_vld && (r_cnt == '0)))
        else $error("hazard_scoreboard: completion with no op outstanding");
      assert (!(w_set && !w_clr && (r_cnt == DEPTH_C)))
        else $error("hazard_scoreboard: issue with all slots occupied");
    end
  end
`endif

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, programmable
// load-use bubbles, and MUL/DIV scoreboard stalls, with branch flush on top.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MC_DEPTH   = 2
) (
  input logic            clk,
  input logic            rst,
  hazard_unit_mc_if.slave bus
);

  localparam logic [1:0] LU_INIT = 2'(LOAD_STALL - 1);

  lu_state_e r_state;
  lu_state_e w_state_nxt;
  logic [1:0] r_lu_cnt;
  logic [1:0] w_lu_cnt_nxt;
  logic       r_rst_q;

  logic w_blank;
  logic w_lu_hit;
  logic w_lu_stall;
  logic w_sb_raw;
  logic w_sb_full;
  logic w_sb_release;
  logic w_sb_busy;
  logic w_mc_struct;
  logic w_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    if (we_m && (rd_m != '0) && (rs == rd_m))      return FWD_MEM;
    else if (we_w && (rd_w != '0) && (rs == rd_w)) return FWD_WB;
    else                                           return FWD_RF;
  endfunction

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .MC_DEPTH (MC_DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set_vld (bus.McStartE),
    .i_set_rd  (bus.RdE),
    .i_clr_vld (bus.McDoneW),
    .i_clr_rd  (bus.McRdW),
    .i_q1_rd   (bus.Rs1D),
    .i_q2_rd   (bus.Rs2D),
    .o_raw_hit (w_sb_raw),
    .o_full    (w_sb_full),
    .o_release (w_sb_release),
    .o_busy    (w_sb_busy)
  );

  // Outputs are held quiet while in reset and for one cycle afterwards.
  assign w_blank = rst || r_rst_q;

  assign w_lu_hit = !w_blank && (bus.ResultSrcE == RESULT_SRC_MEM) && (bus.RdE != '0) &&
                    ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));

  assign w_mc_struct = bus.McOpD && w_sb_full && !w_sb_release;
  assign w_stall     = w_lu_stall || w_sb_raw || w_mc_struct;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lu_cnt <= '0;
      r_rst_q  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
      r_rst_q  <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lu_cnt_nxt = r_lu_cnt;
    w_lu_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_lu_hit) begin
          w_lu_stall = 1'b1;
          if (LOAD_STALL > 1) begin
            w_state_nxt  = LU_STALL;
            w_lu_cnt_nxt = LU_INIT;
          end
        end
      end
      LU_STALL: begin
        w_lu_stall = 1'b1;
        if (r_lu_cnt <= 2'd1) begin
          w_state_nxt  = IDLE;
          w_lu_cnt_nxt = '0;
        end else begin
          w_lu_cnt_nxt = r_lu_cnt - 2'd1;
        end
      end
    endcase
    // A resolved branch kills the younger stalled instructions.
    if (bus.PCSrcE) begin
      w_state_nxt  = IDLE;
      w_lu_cnt_nxt = '0;
    end
  end

  always_comb begin
    bus.ForwardAE = FWD_RF;
    bus.ForwardBE = FWD_RF;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.McBusy    = 1'b0;
    if (!w_blank) begin
      bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
      bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
      bus.McBusy    = w_sb_busy;
      if (bus.PCSrcE) begin
        bus.FlushD = 1'b1;
        bus.FlushE = 1'b1;
      end else begin
        bus.StallF = w_stall;
        bus.StallD = w_stall;
        bus.FlushE = w_stall;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with LOAD_STALL=2, MC_DEPTH=2.
module tb_hazard_unit_mc;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hazard_unit_mc_if #(.REG_AW(5)) hz ();

  hazard_unit_mc #(
    .REG_AW     (5),
    .LOAD_STALL (2),
    .MC_DEPTH   (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {StallF, StallD, FlushD, FlushE}
  function automatic logic [3:0] ctl();
    return {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
  endfunction

  function automatic logic [8:0] outs();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.McBusy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.McOpD = 1'b0;
    hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0; hz.ResultSrcE = 2'b00;
    hz.McStartE = 1'b0; hz.PCSrcE = 1'b0;
    hz.RdM = '0; hz.RegWriteM = 1'b0;
    hz.RdW = '0; hz.RegWriteW = 1'b0;
    hz.McDoneW = 1'b0; hz.McRdW = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    hz.RegWriteM = 1'b1; hz.RdM = 5; hz.Rs1E = 5;
    hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3;
    tick(); #2;
    n_cmp++;
    if (outs() !== 9'b0) begin n_bad++; $display("FAIL reset_cycle: got %b want %b", outs(), 9'b0); end
    tick();
    rst = 1'b0;
    drive_idle();
    #2;
    n_cmp++;
    if (outs() !== 9'b0) begin n_bad++; $display("FAIL reset_after: got %b want %b", outs(), 9'b0); end
    tick();
  endtask

  task automatic test_forward();
    drive_idle();
    hz.RegWriteM = 1'b1; hz.RdM = 5; hz.Rs1E = 5; #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b10) begin n_bad++; $display("FAIL fwd_a_mem: got %b want %b", hz.ForwardAE, 2'b10); end
    n_cmp++;
    if (hz.ForwardBE !== 2'b00) begin n_bad++; $display("FAIL fwd_b_none: got %b want %b", hz.ForwardBE, 2'b00); end
    hz.RdM = 0; hz.Rs1E = 0; #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b00) begin n_bad++; $display("FAIL fwd_a_x0: got %b want %b", hz.ForwardAE, 2'b00); end
    hz.RegWriteM = 1'b0; hz.RdW = 6; hz.RegWriteW = 1'b1; hz.Rs2E = 6; #1;
    n_cmp++;
    if (hz.ForwardBE !== 2'b01) begin n_bad++; $display("FAIL fwd_b_wb: got %b want %b", hz.ForwardBE, 2'b01); end
    hz.RegWriteM = 1'b1; hz.RdM = 9; hz.RdW = 9; hz.Rs1E = 9; hz.Rs2E = 9; #1;
    n_cmp++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b1010) begin
      n_bad++; $display("FAIL fwd_mem_priority: got %b want %b", {hz.ForwardAE, hz.ForwardBE}, 4'b1010);
    end
    hz.RegWriteM = 1'b0; #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b01) begin n_bad++; $display("FAIL fwd_a_wb: got %b want %b", hz.ForwardAE, 2'b01); end
    hz.RdW = 0; hz.Rs1E = 0; #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b00) begin n_bad++; $display("FAIL fwd_a_wb_x0: got %b want %b", hz.ForwardAE, 2'b00); end
    tick();
  endtask

  task automatic test_load_use();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3; #2;
    n_cmp++;
    if (ctl() !== 4'b1101) begin n_bad++; $display("FAIL lu_rs1_c0: got %b want %b", ctl(), 4'b1101); end
    tick();
    drive_idle();
    hz.Rs1D = 3; hz.RdM = 3; hz.RegWriteM = 1'b1; #2;
    n_cmp++;
    if (ctl() !== 4'b1101) begin n_bad++; $display("FAIL lu_rs1_c1: got %b want %b", ctl(), 4'b1101); end
    tick();
    drive_idle();
    hz.Rs1E = 3; hz.RdW = 3; hz.RegWriteW = 1'b1; #2;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL lu_rs1_c2: got %b want %b", ctl(), 4'b0000); end
    n_cmp++;
    if (hz.ForwardAE !== 2'b01) begin n_bad++; $display("FAIL lu_fwd_wb: got %b want %b", hz.ForwardAE, 2'b01); end
    tick();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 0; #1;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL lu_x0: got %b want %b", ctl(), 4'b0000); end
    hz.ResultSrcE = 2'b00; hz.RdE = 4; hz.Rs2D = 4; #1;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL lu_not_load: got %b want %b", ctl(), 4'b0000); end
    tick();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 4; hz.Rs2D = 4; #2;
    n_cmp++;
    if (ctl() !== 4'b1101) begin n_bad++; $display("FAIL lu_rs2_c0: got %b want %b", ctl(), 4'b1101); end
    tick();
    drive_idle(); #2;
    n_cmp++;
    if (ctl() !== 4'b1101) begin n_bad++; $display("FAIL lu_rs2_c1: got %b want %b", ctl(), 4'b1101); end
    tick(); #2;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL lu_rs2_c2: got %b want %b", ctl(), 4'b0000); end
    tick();
  endtask

  task automatic test_mc_raw();
    drive_idle();
    hz.McStartE = 1'b1; hz.RdE = 7; #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b00000) begin n_bad++; $display("FAIL raw_issue: got %b want %b", {ctl(), hz.McBusy}, 5'b00000); end
    tick();
    drive_idle();
    hz.Rs2D = 7; #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b11011) begin n_bad++; $display("FAIL raw_stall1: got %b want %b", {ctl(), hz.McBusy}, 5'b11011); end
    tick(); #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b11011) begin n_bad++; $display("FAIL raw_stall2: got %b want %b", {ctl(), hz.McBusy}, 5'b11011); end
    tick();
    hz.McDoneW = 1'b1; hz.McRdW = 7; hz.RdW = 7; hz.RegWriteW = 1'b1; #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b00001) begin n_bad++; $display("FAIL raw_release: got %b want %b", {ctl(), hz.McBusy}, 5'b00001); end
    tick();
    drive_idle();
    hz.Rs2E = 7; hz.RdW = 7; hz.RegWriteW = 1'b1; #2;
    n_cmp++;
    if ({hz.ForwardBE, hz.McBusy} !== 3'b010) begin
      n_bad++; $display("FAIL raw_fwd_idle: got %b want %b", {hz.ForwardBE, hz.McBusy}, 3'b010);
    end
    tick();
  endtask

  task automatic test_mc_struct();
    drive_idle();
    hz.McStartE = 1'b1; hz.RdE = 8;
    tick();
    hz.RdE = 9;
    tick();
    drive_idle();
    hz.McOpD = 1'b1; #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b11011) begin n_bad++; $display("FAIL full_stall: got %b want %b", {ctl(), hz.McBusy}, 5'b11011); end
    tick();
    hz.McDoneW = 1'b1; hz.McRdW = 8; #2;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL full_release: got %b want %b", ctl(), 4'b0000); end
    tick();
    drive_idle();
    hz.McOpD = 1'b1; #2;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL one_left: got %b want %b", ctl(), 4'b0000); end
    tick();
    drive_idle();
    hz.McStartE = 1'b1; hz.RdE = 9; hz.McDoneW = 1'b1; hz.McRdW = 9;
    tick();
    drive_idle();
    hz.Rs1D = 9; #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b11011) begin n_bad++; $display("FAIL set_wins: got %b want %b", {ctl(), hz.McBusy}, 5'b11011); end
    tick();
    hz.McDoneW = 1'b1; hz.McRdW = 9; #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b00001) begin n_bad++; $display("FAIL last_release: got %b want %b", {ctl(), hz.McBusy}, 5'b00001); end
    tick();
    drive_idle(); #2;
    n_cmp++;
    if (hz.McBusy !== 1'b0) begin n_bad++; $display("FAIL busy_drop: got %b want %b", hz.McBusy, 1'b0); end
    tick();
  endtask

  task automatic test_pcsrc();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3; hz.PCSrcE = 1'b1; #2;
    n_cmp++;
    if (ctl() !== 4'b0011) begin n_bad++; $display("FAIL br_hit_cycle: got %b want %b", ctl(), 4'b0011); end
    tick();
    drive_idle();
    hz.Rs1D = 3; #2;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL br_fsm_idle: got %b want %b", ctl(), 4'b0000); end
    tick();
    hz.ResultSrcE = 2'b01; hz.RdE = 3;
    tick();
    drive_idle();
    hz.PCSrcE = 1'b1; #2;
    n_cmp++;
    if (ctl() !== 4'b0011) begin n_bad++; $display("FAIL br_lu_stall: got %b want %b", ctl(), 4'b0011); end
    tick();
    drive_idle(); #2;
    n_cmp++;
    if (ctl() !== 4'b0000) begin n_bad++; $display("FAIL br_after: got %b want %b", ctl(), 4'b0000); end
    tick();
  endtask

  task automatic test_rst_mid();
    drive_idle();
    hz.McStartE = 1'b1; hz.RdE = 11;
    tick();
    hz.RdE = 12;
    tick();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3;
    tick();
    drive_idle();
    hz.Rs1D = 11; hz.Rs2D = 12; #1;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b11011) begin n_bad++; $display("FAIL mid_pre: got %b want %b", {ctl(), hz.McBusy}, 5'b11011); end
    rst = 1'b1; #1;
    n_cmp++;
    if (outs() !== 9'b0) begin n_bad++; $display("FAIL mid_rst_cycle: got %b want %b", outs(), 9'b0); end
    tick();
    rst = 1'b0; #2;
    n_cmp++;
    if (outs() !== 9'b0) begin n_bad++; $display("FAIL mid_rst_after: got %b want %b", outs(), 9'b0); end
    tick(); #2;
    n_cmp++;
    if ({ctl(), hz.McBusy} !== 5'b00000) begin n_bad++; $display("FAIL mid_cleared: got %b want %b", {ctl(), hz.McBusy}, 5'b00000); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive_idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mc_raw();
    test_mc_struct();
    test_pcsrc();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
